// File: rtl/conv_window_sched.sv
// conv_window_sched: sequencer for the 3x3 convolution engine.
// After one accepted start it walks every kernel channel and every valid
// output position. For each window it issues image-column loads and a calc
// pulse. At each channel start it also issues weight-column loads. It then
// waits for the engine sum, applies optional ReLU and presents one tagged
// result on a valid/ready port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, relu_en      job launch (sampled in IDLE), ReLU select captured at launch
//   busy, done          job in progress, one-cycle completion pulse
//   w_ld, w_ch, w_col   weight-column load strobe with kernel index and column
//   img_ld, img_row,    image-column load strobe with window top row and
//   img_col             image column
//   calc                one-cycle compute pulse
//   eng_valid, eng_data engine result (signed 24-bit)
//   out_valid, out_ready, out_data, out_ch, out_row, out_col
//                       tagged result handshake
module conv_window_sched #(
   parameter  int unsigned K_H  = 3,
   parameter  int unsigned K_W  = 3,
   parameter  int unsigned IN_H = 16,
   parameter  int unsigned IN_W = 15,
   parameter  int unsigned CHAN = 10,
   localparam int unsigned RW   = (IN_H > 1) ? $clog2(IN_H) : 1,
   localparam int unsigned CW   = (IN_W > 1) ? $clog2(IN_W) : 1,
   localparam int unsigned HW   = (CHAN > 1) ? $clog2(CHAN) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          relu_en,
   output logic          busy,
   output logic          done,
   output logic          w_ld,
   output logic [HW-1:0] w_ch,
   output logic [1:0]    w_col,
   output logic          img_ld,
   output logic [RW-1:0] img_row,
   output logic [CW-1:0] img_col,
   output logic          calc,
   input  logic          eng_valid,
   input  logic [23:0]   eng_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [23:0]   out_data,
   output logic [HW-1:0] out_ch,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col
);

   localparam int unsigned OUT_H = IN_H - K_H + 1;
   localparam int unsigned OUT_W = IN_W - K_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_ILOAD,
      S_CALC,
      S_WAIT,
      S_OUT,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [1:0]    r_beat;
   logic [HW-1:0] r_ch;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          r_relu;

   logic          r_busy;
   logic          r_done;
   logic          r_w_ld;
   logic [HW-1:0] r_w_ch;
   logic [1:0]    r_w_col;
   logic          r_img_ld;
   logic [RW-1:0] r_img_row;
   logic [CW-1:0] r_img_col;
   logic          r_calc;
   logic          r_out_valid;
   logic [23:0]   r_out_data;
   logic [HW-1:0] r_out_ch;
   logic [RW-1:0] r_out_row;
   logic [CW-1:0] r_out_col;

   logic w_beat_last;
   logic w_col_last;
   logic w_row_last;
   logic w_ch_last;

   // Wrap points of the beat and window counters
   assign w_beat_last = (r_beat == 2'(K_W - 1));
   assign w_col_last  = (r_col  == CW'(OUT_W - 1));
   assign w_row_last  = (r_row  == RW'(OUT_H - 1));
   assign w_ch_last   = (r_ch   == HW'(CHAN - 1));

   // Sequencer: outputs are registered and updated on the edge that enters
   // the state they belong to, so they line up with the state cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_ch        <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_relu      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_w_ld      <= 1'b0;
         r_w_ch      <= '0;
         r_w_col     <= '0;
         r_img_ld    <= 1'b0;
         r_img_row   <= '0;
         r_img_col   <= '0;
         r_calc      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_relu  <= relu_en;
                  r_ch    <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_beat  <= '0;
                  r_busy  <= 1'b1;
                  r_w_ld  <= 1'b1;
                  r_w_ch  <= '0;
                  r_w_col <= '0;
                  r_state <= S_WLOAD;
               end
            end

            S_WLOAD: begin
               if (w_beat_last) begin
                  r_beat    <= '0;
                  r_w_ld    <= 1'b0;
                  r_w_ch    <= '0;
                  r_w_col   <= '0;
                  r_img_ld  <= 1'b1;
                  r_img_row <= r_row;
                  r_img_col <= r_col;
                  r_state   <= S_ILOAD;
               end else begin
                  r_beat  <= r_beat + 2'd1;
                  r_w_col <= r_beat + 2'd1;
               end
            end

            S_ILOAD: begin
               if (w_beat_last) begin
                  r_beat    <= '0;
                  r_img_ld  <= 1'b0;
                  r_img_row <= '0;
                  r_img_col <= '0;
                  r_calc    <= 1'b1;
                  r_state   <= S_CALC;
               end else begin
                  r_beat    <= r_beat + 2'd1;
                  r_img_col <= r_col + CW'(r_beat) + CW'(1);
               end
            end

            S_CALC: begin
               r_calc  <= 1'b0;
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               if (eng_valid) begin
                  // ReLU clamps negative sums to zero
                  r_out_data  <= (r_relu && eng_data[23]) ? '0 : eng_data;
                  r_out_ch    <= r_ch;
                  r_out_row   <= r_row;
                  r_out_col   <= r_col;
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end
            end

            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (!w_col_last) begin
                     r_col     <= r_col + CW'(1);
                     r_img_ld  <= 1'b1;
                     r_img_row <= r_row;
                     r_img_col <= r_col + CW'(1);
                     r_state   <= S_ILOAD;
                  end else if (!w_row_last) begin
                     r_col     <= '0;
                     r_row     <= r_row + RW'(1);
                     r_img_ld  <= 1'b1;
                     r_img_row <= r_row + RW'(1);
                     r_img_col <= '0;
                     r_state   <= S_ILOAD;
                  end else if (!w_ch_last) begin
                     // New kernel: reload weights before the first window
                     r_col   <= '0;
                     r_row   <= '0;
                     r_ch    <= r_ch + HW'(1);
                     r_w_ld  <= 1'b1;
                     r_w_ch  <= r_ch + HW'(1);
                     r_w_col <= '0;
                     r_state <= S_WLOAD;
                  end else begin
                     r_col   <= '0;
                     r_row   <= '0;
                     r_ch    <= '0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign w_ld      = r_w_ld;
   assign w_ch      = r_w_ch;
   assign w_col     = r_w_col;
   assign img_ld    = r_img_ld;
   assign img_row   = r_img_row;
   assign img_col   = r_img_col;
   assign calc      = r_calc;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;

endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: randomized bench for conv_window_sched (default size).
// An engine model answers each calc after a random 1-4 cycle latency with
// random data. The expected window order comes from plain index arithmetic
// over (ch,row,col). Expected results are queued with ReLU applied
// arithmetically. Three jobs run: ReLU on, a job aborted by reset in the
// WAIT of window 3, and ReLU off. Spurious start/eng_valid pulses and
// out_ready stalls are mixed in.
module tb_conv_window_sched;

   localparam int unsigned K_H   = 3;
   localparam int unsigned K_W   = 3;
   localparam int unsigned IN_H  = 16;
   localparam int unsigned IN_W  = 15;
   localparam int unsigned CHAN  = 10;
   localparam int unsigned OUT_H = IN_H - K_H + 1;
   localparam int unsigned OUT_W = IN_W - K_W + 1;
   localparam int unsigned NWIN  = CHAN * OUT_H * OUT_W;
   localparam int unsigned RW    = $clog2(IN_H);
   localparam int unsigned CW    = $clog2(IN_W);
   localparam int unsigned HW    = $clog2(CHAN);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          relu_en;
   logic          busy;
   logic          done;
   logic          w_ld;
   logic [HW-1:0] w_ch;
   logic [1:0]    w_col;
   logic          img_ld;
   logic [RW-1:0] img_row;
   logic [CW-1:0] img_col;
   logic          calc;
   logic          eng_valid;
   logic [23:0]   eng_data;
   logic          out_valid;
   logic          out_ready;
   logic [23:0]   out_data;
   logic [HW-1:0] out_ch;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;

   conv_window_sched #(
      .K_H(K_H), .K_W(K_W), .IN_H(IN_H), .IN_W(IN_W), .CHAN(CHAN)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
      .busy(busy), .done(done),
      .w_ld(w_ld), .w_ch(w_ch), .w_col(w_col),
      .img_ld(img_ld), .img_row(img_row), .img_col(img_col),
      .calc(calc), .eng_valid(eng_valid), .eng_data(eng_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_row(out_row), .out_col(out_col)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] d;
      logic [31:0] ch;
      logic [31:0] row;
      logic [31:0] col;
   } res_t;

   res_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   bit relu_m, abort_job, want_start, job_end, idle_m, busy_exp, ov_exp, stalled5;
   int start_cyc, done_exp_cyc, eng_due, eng_idx, abort_cyc, stall_cnt;
   int n_calc, n_res, n_wld, n_img, n_done, wbeat, ibeat;

   function automatic int win_ch(input int i);
      return i / int'(OUT_H * OUT_W);
   endfunction
   function automatic int win_row(input int i);
      return (i / int'(OUT_W)) % int'(OUT_H);
   endfunction
   function automatic int win_col(input int i);
      return i % int'(OUT_W);
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 32'({busy, done, w_ld, img_ld, calc, out_valid}), 32'd0);
      chk({tag, "_idx"}, 32'({w_ch, w_col, img_row, img_col}), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_tags"}, 32'({out_ch, out_row, out_col}), 32'd0);
   endtask

   task automatic model_clear();
      busy_exp     = 1'b0;
      ov_exp       = 1'b0;
      idle_m       = 1'b1;
      want_start   = 1'b0;
      done_exp_cyc = -1;
      eng_due      = -1;
      abort_cyc    = -1;
      exp_q.delete();
   endtask

   // One clock: sample and check outputs after the edge, then drive inputs
   task automatic cycle();
      res_t        r;
      logic [23:0] d;
      bit          hs;
      @(posedge clk);
      #1;
      cyc++;

      chk("busy", 32'(busy), 32'(busy_exp));
      chk("done", 32'(done), 32'(cyc == done_exp_cyc));
      chk("out_valid", 32'(out_valid), 32'(ov_exp));
      chk("strobe_excl", 32'(int'(w_ld) + int'(img_ld) + int'(calc) <= 1), 32'd1);
      if (done) n_done++;
      if (!w_ld)   chk("w_idx_zero", 32'({w_ch, w_col}), 32'd0);
      if (!img_ld) chk("img_idx_zero", 32'({img_row, img_col}), 32'd0);

      if (ov_exp) begin
         chk("out_no_strobe", 32'({w_ld, img_ld, calc}), 32'd0);
         if (exp_q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].d));
            chk("out_ch", 32'(out_ch), exp_q[0].ch);
            chk("out_row", 32'(out_row), exp_q[0].row);
            chk("out_col", 32'(out_col), exp_q[0].col);
         end
      end

      if (w_ld) begin
         n_wld++;
         chk("w_ch", 32'(w_ch), 32'(win_ch(n_calc)));
         chk("w_col", 32'(w_col), 32'(wbeat));
         chk("w_ld_at_chan_start", 32'(win_row(n_calc) == 0 && win_col(n_calc) == 0), 32'd1);
         wbeat++;
      end

      if (img_ld) begin
         n_img++;
         chk("img_row", 32'(img_row), 32'(win_row(n_calc)));
         chk("img_col", 32'(img_col), 32'(win_col(n_calc) + ibeat));
         ibeat++;
      end

      if (calc) begin
         chk("iload_len", 32'(ibeat), 32'(K_W));
         chk("wload_len", 32'(wbeat),
             32'((win_row(n_calc) == 0 && win_col(n_calc) == 0) ? K_W : 0));
         if (n_calc == 0) chk("first_calc", 32'(cyc - start_cyc), 32'(2 * K_W + 1));
         ibeat   = 0;
         wbeat   = 0;
         eng_idx = n_calc;
         n_calc++;
         eng_due = cyc + int'($urandom_range(4, 1));
         if (abort_job && n_calc == 3) abort_cyc = cyc + 1;
      end

      // ---- drive phase ----
      start     = 1'b0;
      relu_en   = 1'($urandom);
      eng_valid = 1'b0;
      eng_data  = 24'($urandom);

      if (cyc == abort_cyc) begin
         rst = 1'b1;
         #1;
         check_zero("abort");
         model_clear();
         job_end = 1'b1;
         return;
      end

      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else if (ov_exp && n_res == 5 && !stalled5) begin
         out_ready = 1'b0;
         stall_cnt = 4;
         stalled5  = 1'b1;
      end else begin
         out_ready = ($urandom_range(3, 0) != 0);
      end
      hs = ov_exp && out_ready;

      if (cyc == eng_due) begin
         if (eng_idx == 0)      d = 24'hFFFFFB;
         else if (eng_idx == 1) d = 24'd7;
         else                   d = 24'($urandom);
         eng_valid = 1'b1;
         eng_data  = d;
         r.d   = (relu_m && $signed(d) < 0) ? 24'd0 : d;
         r.ch  = 32'(win_ch(eng_idx));
         r.row = 32'(win_row(eng_idx));
         r.col = 32'(win_col(eng_idx));
         exp_q.push_back(r);
      end else if ((img_ld || ov_exp) && $urandom_range(15, 0) == 0) begin
         eng_valid = 1'b1;
      end

      if (hs) begin
         if (n_res == 0) chk("relu_first", 32'(out_data), relu_m ? 32'd0 : 32'h00FFFFFB);
         if (n_res == 1) chk("relu_second", 32'(out_data), 32'd7);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         n_res++;
         ov_exp = 1'b0;
         if (n_res == int'(NWIN)) done_exp_cyc = cyc + 1;
      end
      if (cyc == eng_due) ov_exp = 1'b1;

      if (want_start && idle_m) begin
         start      = 1'b1;
         relu_en    = relu_m;
         want_start = 1'b0;
         idle_m     = 1'b0;
         busy_exp   = 1'b1;
         start_cyc  = cyc;
      end else if (!idle_m && $urandom_range(199, 0) == 0) begin
         start = 1'b1;
      end

      if (cyc == done_exp_cyc) begin
         busy_exp = 1'b0;
         idle_m   = 1'b1;
         job_end  = 1'b1;
      end
   endtask

   task automatic run_job(input bit relu, input bit abort);
      int limit;
      relu_m     = relu;
      abort_job  = abort;
      want_start = 1'b1;
      job_end    = 1'b0;
      n_calc = 0; n_res = 0; n_wld = 0; n_img = 0; n_done = 0;
      wbeat  = 0; ibeat = 0; stall_cnt = 0; stalled5 = 1'b0;
      limit  = cyc + 30000;
      while (!job_end && cyc < limit) cycle();
      chk("job_finished", 32'(job_end), 32'd1);
      if (abort) begin
         chk("abort_no_done", 32'(n_done), 32'd0);
      end else begin
         chk("n_results", 32'(n_res), 32'(NWIN));
         chk("n_calc", 32'(n_calc), 32'(NWIN));
         chk("n_w_ld", 32'(n_wld), 32'(CHAN * K_W));
         chk("n_img_ld", 32'(n_img), 32'(NWIN * K_W));
         chk("n_done", 32'(n_done), 32'd1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      relu_en   = 1'b0;
      eng_valid = 1'b0;
      eng_data  = '0;
      out_ready = 1'b0;
      stall_cnt = 0;
      start_cyc = 0;
      eng_idx   = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      run_job(1'b1, 1'b0);
      repeat (3) cycle();

      run_job(1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_zero("post_abort");
      rst = 1'b0;
      n_done = 0;
      repeat (4) cycle();
      chk("idle_after_abort_no_done", 32'(n_done), 32'd0);

      run_job(1'b0, 1'b0);
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
